// File: rtl/pr_bridge_ic.sv
// CPU peripheral-bus bridge: decodes NDEV device windows plus an interrupt
// controller window, muxes read data and drives the CPU HWInt lines.
module pr_bridge_ic #(
  parameter int unsigned NDEV       = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter bit          EDGE       = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 PrWe,
  output logic [31:0]          PrRD,
  output logic [NDEV-1:0]      DevWe,
  input  logic [32*NDEV-1:0]   DevRD,
  input  logic [NDEV-1:0]      DevIRQ,
  input  logic                 ExtIRQ,
  output logic [5:0]           HWInt
);

  localparam int unsigned NSRC    = NDEV + 1;
  localparam logic [32:0] IC_BASE = {1'b0, DEV_BASE} + 33'(NDEV) * {1'b0, DEV_STRIDE};

  // One extra address bit keeps window limits at the top of memory from wrapping.
  logic [32:0] addr_x;
  assign addr_x = {1'b0, PrAddr};

  logic [NDEV-1:0] sel;

  for (genvar g = 0; g < NDEV; g++) begin : g_dec
    localparam logic [32:0] LO = {1'b0, DEV_BASE} + 33'(g) * {1'b0, DEV_STRIDE};
    assign sel[g]   = (addr_x >= LO) && (addr_x < LO + {1'b0, DEV_STRIDE});
    assign DevWe[g] = PrWe & sel[g];
  end

  logic       ic_sel;
  logic [1:0] ic_off;
  logic       mask_we;
  logic       pend_we;

  assign ic_sel  = (addr_x >= IC_BASE) && (addr_x < IC_BASE + 33'd16);
  assign ic_off  = 2'((PrAddr - IC_BASE[31:0]) >> 2);
  assign mask_we = PrWe & ic_sel & (ic_off == 2'd0);
  assign pend_we = PrWe & ic_sel & (ic_off == 2'd1);

  logic unused_wd;
  assign unused_wd = ^PrWD[31:NSRC];

  logic [NDEV:0] raw;
  logic [NDEV:0] prev_q;
  logic [NDEV:0] mask_q, mask_d;
  logic [NDEV:0] pend_q, pend_d;
  logic [NDEV:0] pend_hold;
  logic [NDEV:0] set_v;
  logic [NDEV:0] clr_v;
  logic [5:0]    hwint_q, hwint_d;

  assign raw   = {ExtIRQ, DevIRQ};
  assign set_v = raw & ~prev_q;
  assign clr_v = pend_we ? PrWD[NDEV:0] : '0;

  // pend_hold is what survives this cycle's W1C; a new edge on the same bit
  // wins, so that bit is neither cleared in pending nor dropped from HWInt.
  always_comb begin
    mask_d = mask_q;
    if (mask_we) mask_d = PrWD[NDEV:0];
    if (EDGE) begin
      pend_hold = pend_q & ~(clr_v & ~set_v);
      pend_d    = pend_hold | set_v;
    end else begin
      pend_hold = pend_q;
      pend_d    = raw;
    end
    hwint_d         = '0;
    hwint_d[NDEV:0] = pend_hold & mask_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      mask_q  <= '1;
      pend_q  <= '0;
      hwint_q <= '0;
    end else begin
      prev_q  <= raw;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt = hwint_q;

  logic [31:0] ic_rd;

  always_comb begin
    ic_rd = '0;
    case (ic_off)
      2'd0:    ic_rd[NDEV:0] = mask_q;
      2'd1:    ic_rd[NDEV:0] = pend_q;
      2'd2:    ic_rd[NDEV:0] = raw;
      default: ic_rd = '0;
    endcase
    PrRD = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel[i]) PrRD = DevRD[32*i +: 32];
    end
    if (ic_sel) PrRD = ic_rd;
  end

endmodule
